// File: rtl/fifo_burst_reader.sv
// Purpose: reads burst_len words from a registered-output FIFO and streams them downstream.
// Latency: fifo_rd one cycle after start is accepted; out_valid two edges after start.
// Backpressure: up to three words are read ahead into the local buffer, then issue stalls.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_left,
  output logic             fifo_rd,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q;
  logic [LEN_W-1:0] words_left_q;
  logic [LEN_W-1:0] issue_q;
  logic [WIDTH-1:0] buf_q [3];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             capture;
  logic             accept;
  logic [2:0]       pending;

  // Three-entry ring: pointers wrap 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words held plus the one still coming back from the FIFO; issue only if a slot is guaranteed.
  assign pending    = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fifo_rd    = (state_q == RUN) && (issue_q != '0) && !fifo_empty && (pending < 3'd3);
  assign capture    = inflight_q;
  assign out_valid  = (occ_q != 2'd0);
  assign accept     = out_valid && out_ready;
  assign out_data   = buf_q[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign words_left = words_left_q;

  // Next pointers and occupancy; a simultaneous capture and accept leaves occupancy unchanged.
  always_comb begin
    wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = accept  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (capture && !accept) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && accept) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Buffer storage, pointers and the read-in-flight flag (FIFO data lands one cycle after fifo_rd).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      if (capture) begin
        buf_q[wr_ptr_q] <= fifo_data;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
    end
  end

  // Burst control: start capture, issue countdown, completion on the last accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      issue_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state_q      <= RUN;
              words_left_q <= burst_len;
              issue_q      <= burst_len;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (fifo_rd) begin
            issue_q <= issue_q - LEN_ONE;
          end
          if (accept && (words_left_q != '0)) begin
            words_left_q <= words_left_q - LEN_ONE;
            if (words_left_q == LEN_ONE) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO environment, count-based reference model, per-cycle compare
// plus directed scenarios with literal expectations.
module tb_fifo_burst_reader;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       start     = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       out_ready = 1'b0;
  logic       busy, done, fifo_rd, out_valid, fifo_empty;
  logic [7:0] words_left, out_data;
  logic [7:0] fifo_data = 8'd0;

  logic [7:0] fmem [64];
  int fifo_wr  = 0;
  int fifo_rdi = 0;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int busy_cyc = 0;

  // Reference model: burst phase (0 idle, 1 run, 2 done) and word counts.
  int m_phase = 0;
  int m_len   = 0;
  int m_pops  = 0;
  int m_capt  = 0;
  int m_acc   = 0;
  int m_base  = 0;
  bit m_infl  = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = (fifo_wr == fifo_rdi);

  fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .words_left(words_left),
    .fifo_rd   (fifo_rd),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // FIFO with registered read data
  always @(posedge clk) begin
    if (fifo_rd && (fifo_rdi != fifo_wr)) begin
      fifo_data <= fmem[fifo_rdi];
      fifo_rdi  <= fifo_rdi + 1;
    end
  end

  always @(negedge clk) begin
    done_cnt <= done_cnt + int'(done);
    busy_cyc <= busy_cyc + int'(busy);
  end

  function automatic bit f_valid();
    return (m_capt - m_acc) > 0;
  endfunction

  function automatic bit f_rd();
    return (m_phase == 1) && (m_pops < m_len) && !fifo_empty &&
           ((m_capt - m_acc + int'(m_infl)) < 3);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_len <= 0; m_pops <= 0; m_capt <= 0;
      m_acc <= 0; m_base <= 0; m_infl <= 1'b0;
    end else begin
      m_capt <= m_capt + int'(m_infl);
      m_infl <= f_rd();
      m_pops <= m_pops + int'(f_rd());
      case (m_phase)
        0: begin
          if (start) begin
            if (burst_len != 8'd0) begin
              m_phase <= 1;
              m_len   <= int'(burst_len);
              m_acc   <= 0;
              m_pops  <= 0;
              m_capt  <= 0;
              m_infl  <= 1'b0;
              m_base  <= fifo_rdi;
            end else begin
              m_phase <= 2;
            end
          end
        end
        1: begin
          if (f_valid() && out_ready) begin
            m_acc <= m_acc + 1;
            if (m_acc + 1 == m_len) m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[fifo_wr] = v;
    fifo_wr = fifo_wr + 1;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    start     = 1'b1;
    burst_len = len;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  int p0, d0, b0, n;

  initial begin
    tick(2);
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_left", words_left, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);

    fork
      forever begin
        @(negedge clk);
        check("cmp_busy", busy, m_phase != 0);
        check("cmp_done", done, m_phase == 2);
        check("cmp_words_left", words_left, 8'(m_len - m_acc));
        check("cmp_fifo_rd", fifo_rd, f_rd());
        check("cmp_out_valid", out_valid, f_valid());
        if (f_valid()) check("cmp_out_data", out_data, fmem[m_base + m_acc]);
        check("cmp_rd_when_empty", fifo_rd && fifo_empty, 0);
      end
    join_none

    rst = 1'b0;
    tick(1);

    // 1: burst of 4, sink always ready
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    out_ready = 1'b1;
    p0 = fifo_rdi; d0 = done_cnt;
    pulse_start(8'd4);
    @(negedge clk);
    check("t1_rd_after_e0", fifo_rd, 1);
    check("t1_valid_after_e0", out_valid, 0);
    tick(1);
    @(negedge clk);
    check("t1_valid_after_e1", out_valid, 0);
    tick(1);
    @(negedge clk);
    check("t1_valid_after_e2", out_valid, 1);
    check("t1_first_word", out_data, 8'h11);
    wait_idle();
    check("t1_pops", fifo_rdi - p0, 4);
    check("t1_done_pulses", done_cnt - d0, 1);

    // 2: burst of 6 under backpressure
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5); push(8'hA6);
    out_ready = 1'b0;
    p0 = fifo_rdi;
    pulse_start(8'd6);
    tick(10);
    check("t2_stall_pops", fifo_rdi - p0, 3);
    check("t2_held_word", out_data, 8'hA1);
    check("t2_held_valid", out_valid, 1);
    check("t2_words_left", words_left, 6);
    check("t2_rd_stalled", fifo_rd, 0);
    out_ready = 1'b1;
    wait_idle();
    check("t2_pops", fifo_rdi - p0, 6);
    check("t2_words_left_end", words_left, 0);

    // 3: FIFO runs dry mid-burst
    push(8'hB1); push(8'hB2);
    p0 = fifo_rdi; d0 = done_cnt;
    pulse_start(8'd5);
    tick(8);
    check("t3_pops_dry", fifo_rdi - p0, 2);
    check("t3_busy_dry", busy, 1);
    check("t3_rd_dry", fifo_rd, 0);
    check("t3_words_left_dry", words_left, 3);
    push(8'hB3); push(8'hB4); push(8'hB5);
    wait_idle();
    check("t3_pops", fifo_rdi - p0, 5);
    check("t3_done_pulses", done_cnt - d0, 1);

    // 4: zero-length burst
    p0 = fifo_rdi; d0 = done_cnt; b0 = busy_cyc;
    pulse_start(8'd0);
    @(negedge clk);
    check("t4_done_after_e0", done, 1);
    wait_idle();
    tick(2);
    check("t4_pops", fifo_rdi - p0, 0);
    check("t4_busy_cycles", busy_cyc - b0, 1);
    check("t4_done_pulses", done_cnt - d0, 1);

    // 5: start during RUN is ignored
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    p0 = fifo_rdi;
    pulse_start(8'd4);
    tick(1);
    start = 1'b1; burst_len = 8'd9;
    tick(1);
    start = 1'b0;
    wait_idle();
    tick(3);
    check("t5_pops", fifo_rdi - p0, 4);
    check("t5_idle_after", busy, 0);

    // 6: reset mid-burst, then a fresh burst of 2
    for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i));
    pulse_start(8'd8);
    n = 0;
    @(negedge clk);
    while (words_left != 8'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_3_accepted", words_left, 5);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_fifo_rd", fifo_rd, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_words_left", words_left, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    p0 = fifo_rdi;
    pulse_start(8'd2);
    wait_idle();
    check("t6_pops_after_rst", fifo_rdi - p0, 2);
    check("t6_words_left_end", words_left, 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
